// File: rtl/m3_cmd_scheduler.sv
// m3_cmd_scheduler: debounces operator buttons and issues m3 datapath command pulses by fixed priority.
// Ports: clkI/rstI clock and synchronous active-high reset; tick100hzI 100 Hz enable pulse;
// workingI datapath busy flag; btnI[6:0] raw buttons {powerDEC,powerINC,speedDEC,speedINC,
// invRotate,forceStop,start}; m3*O one-clock command pulses; busyO FSM not idle; revErrO
// reversal timeout pulse; stateO FSM state.
// Optional: define M3_CMD_AUTOREPEAT_EN for auto-repeat of held speed/power INC/DEC buttons.
module m3_cmd_scheduler #(
    parameter int DEB_TICKS = 3,
    parameter int REV_TMO   = 200,
    parameter int RPT_DLY   = 50,
    parameter int RPT_PER   = 10
) (
    input  logic       clkI,
    input  logic       rstI,
    input  logic       tick100hzI,
    input  logic       workingI,
    input  logic [6:0] btnI,
    output logic       m3startO,
    output logic       m3forceStopO,
    output logic       m3invRotateO,
    output logic       m3speedINCo,
    output logic       m3speedDECo,
    output logic       m3powerINCo,
    output logic       m3powerDECo,
    output logic       busyO,
    output logic       revErrO,
    output logic [2:0] stateO
);
    if (DEB_TICKS < 1 || DEB_TICKS > 15 || REV_TMO < 1 || REV_TMO > 65535 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_cfg
        $error("m3_cmd_scheduler: parameter out of range");
    end
    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, REV_STOP, REV_WAIT, REV_INV, REV_START} state_t;
    state_t          state_q, state_d;
    logic [6:0]      stable_q, stable_d, pend_q, pend_d, cmd_q, cmd_d;
    logic [6:0][3:0] deb_q, deb_d;
    logic [15:0]     tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [6:0]      rise, req_set, eff, clr, win;
    always_comb begin
        stable_d = stable_q;
        deb_d    = deb_q;
        for (int i = 0; i < 7; i++) begin
            if (tick100hzI) begin
                if (btnI[i] == stable_q[i]) deb_d[i] = '0;
                else if (deb_q[i] + 4'd1 == 4'(DEB_TICKS)) begin
                    deb_d[i]    = '0;
                    stable_d[i] = btnI[i];
                end else deb_d[i] = deb_q[i] + 4'd1;
            end
        end
    end
    assign rise = stable_d & ~stable_q;
`ifdef M3_CMD_AUTOREPEAT_EN
    // Per INC/DEC button countdown: RPT_DLY ticks after the press, then every RPT_PER ticks.
    logic [3:0][15:0] rpt_q, rpt_d;
    logic [3:0]       rep;
    always_comb begin
        rpt_d = rpt_q;
        rep   = '0;
        for (int i = 0; i < 4; i++) begin
            if (!stable_d[i+3]) rpt_d[i] = '0;
            else if (rise[i+3]) rpt_d[i] = 16'(RPT_DLY);
            else if (tick100hzI) begin
                rep[i]   = rpt_q[i] == 16'd1;
                rpt_d[i] = rep[i] ? 16'(RPT_PER) : rpt_q[i] - 16'd1;
            end
        end
    end
    always_ff @(posedge clkI) rpt_q <= rstI ? '0 : rpt_d;
    assign req_set = rise | {rep, 3'b000};
`else
    assign req_set = rise;
`endif
    always_comb begin
        eff = pend_q;
        // Opposing INC/DEC requests cancel each other.
        if (eff[3] && eff[4]) eff[4:3] = 2'b00;
        if (eff[5] && eff[6]) eff[6:5] = 2'b00;
        win = eff[2] ? 7'h04 : eff[0] ? 7'h01 : eff[3] ? 7'h08 : eff[4] ? 7'h10 :
              eff[5] ? 7'h20 : eff[6] ? 7'h40 : 7'h00;
        clr     = pend_q & ~eff;
        state_d = state_q;
        cmd_d   = '0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE:      state_d = (eff[2] && workingI) ? REV_STOP : |(eff & 7'h7D) ? ISSUE : IDLE;
            ISSUE: begin
                cmd_d   = win;
                clr     = clr | win;
                state_d = HOLD;
            end
            HOLD:      state_d = tick100hzI ? IDLE : HOLD;
            REV_STOP: begin
                cmd_d   = 7'h02;
                tmo_d   = 16'(REV_TMO);
                state_d = REV_WAIT;
            end
            REV_WAIT: begin
                if (!workingI) begin
                    cmd_d   = 7'h04;
                    state_d = REV_INV;
                end else if (tick100hzI) begin
                    tmo_d = tmo_q - 16'd1;
                    if (tmo_q == 16'd1) begin
                        err_d   = 1'b1;
                        clr[2]  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            REV_INV:   state_d = tick100hzI ? REV_START : REV_INV;
            REV_START: begin
                cmd_d   = 7'h01;
                clr[2]  = 1'b1;
                state_d = HOLD;
            end
            default:   state_d = IDLE;
        endcase
        // forceStop overrides everything, including a reversal in progress.
        if (pend_q[1]) begin
            cmd_d   = 7'h02;
            clr     = 7'h7F;
            state_d = IDLE;
        end
        pend_d = (pend_q & ~clr) | req_set;
    end
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state_q  <= IDLE;
            stable_q <= '0;
            pend_q   <= '0;
            cmd_q    <= '0;
            deb_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            cmd_q    <= cmd_d;
            deb_q    <= deb_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end
    assign {m3powerDECo, m3powerINCo, m3speedDECo, m3speedINCo, m3invRotateO, m3forceStopO, m3startO} = cmd_q;
    assign busyO   = state_q != IDLE;
    assign revErrO = err_q;
    assign stateO  = state_q;
endmodule
